// File: rtl/qspi_sram_responder.sv
// QSPI SRAM responder: serial enter-quad, quad write (0x02), quad fast read (0x0B)
// and reset-quad (0xFF) with 24-bit addresses into an internal byte array.
// DUMMY_NIBBLES must be in 1..8 (3-bit dummy counter).
module qspi_sram_responder #(
  parameter int unsigned ADDR_BITS     = 10,
  parameter int unsigned DUMMY_NIBBLES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic [3:0] sio_in,
  output logic [3:0] sio_out,
  output logic       sio_oe,
  output logic       quad_mode,
  output logic       cmd_error
);

  typedef enum logic [2:0] {
    StIdle, StSpiCmd, StQCmd, StQAddr, StQWrite, StQDummy, StQRead, StIgnore
  } state_e;

  localparam int unsigned Depth     = 2 ** ADDR_BITS;
  localparam logic [2:0]  DummyLast = 3'(DUMMY_NIBBLES - 1);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           dummy_q, dummy_d;
  logic [7:0]           opcode_q, opcode_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [3:0]           hold_q, hold_d;
  // Write: high nibble captured. Read: high nibble presented, low nibble next.
  logic                 half_q, half_d;
  logic [3:0]           sio_out_q, sio_out_d;
  logic                 sio_oe_q, sio_oe_d;
  logic                 quad_mode_q, quad_mode_d;
  logic                 cmd_error_q, cmd_error_d;
  logic                 mem_we;
  logic [7:0]           mem_rdata;
  logic [7:0]           mem [Depth];

  assign mem_rdata = mem[addr_q];
  assign sio_out   = sio_out_q;
  assign sio_oe    = sio_oe_q;
  assign quad_mode = quad_mode_q;
  assign cmd_error = cmd_error_q;

  // Next-state decode of the bus protocol.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dummy_d     = dummy_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    half_d      = half_q;
    sio_out_d   = sio_out_q;
    sio_oe_d    = 1'b0;
    quad_mode_d = quad_mode_q;
    cmd_error_d = 1'b0;
    mem_we      = 1'b0;

    if (cs_n) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
      dummy_d = 3'd0;
      half_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (quad_mode_q) begin
            opcode_d = {4'h0, sio_in};
            state_d  = StQCmd;
          end else begin
            opcode_d = {7'h00, sio_in[0]};
            cnt_d    = 4'd1;
            state_d  = StSpiCmd;
          end
        end
        StSpiCmd: begin
          opcode_d = {opcode_q[6:0], sio_in[0]};
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            state_d = StIgnore;
            if (opcode_d == 8'h38) quad_mode_d = 1'b1;
            else                   cmd_error_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StQCmd: begin
          opcode_d = {opcode_q[3:0], sio_in};
          cnt_d    = 4'd0;
          case (opcode_d)
            8'h02, 8'h0B: state_d = StQAddr;
            8'hFF: begin
              quad_mode_d = 1'b0;
              state_d     = StIgnore;
            end
            8'h38:   state_d = StIgnore;
            default: begin
              cmd_error_d = 1'b1;
              state_d     = StIgnore;
            end
          endcase
        end
        StQAddr: begin
          // Shifting all six nibbles leaves exactly the low ADDR_BITS of the address.
          addr_d = ADDR_BITS'({addr_q, sio_in});
          if (cnt_q == 4'd5) begin
            cnt_d   = 4'd0;
            dummy_d = 3'd0;
            half_d  = 1'b0;
            state_d = (opcode_q == 8'h02) ? StQWrite : StQDummy;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StQWrite: begin
          if (!half_q) begin
            hold_d = sio_in;
            half_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            addr_d = addr_q + 1'b1;
            half_d = 1'b0;
          end
        end
        StQDummy: begin
          if (dummy_q == DummyLast) begin
            sio_oe_d  = 1'b1;
            sio_out_d = mem_rdata[7:4];
            half_d    = 1'b1;
            state_d   = StQRead;
          end else begin
            dummy_d = dummy_q + 3'd1;
          end
        end
        StQRead: begin
          sio_oe_d = 1'b1;
          if (half_q) begin
            sio_out_d = mem_rdata[3:0];
            addr_d    = addr_q + 1'b1;
            half_d    = 1'b0;
          end else begin
            sio_out_d = mem_rdata[7:4];
            half_d    = 1'b1;
          end
        end
        default: ;  // StIgnore: wait for cs_n to rise
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      dummy_q     <= 3'd0;
      opcode_q    <= 8'h00;
      addr_q      <= '0;
      hold_q      <= 4'h0;
      half_q      <= 1'b0;
      sio_out_q   <= 4'h0;
      sio_oe_q    <= 1'b0;
      quad_mode_q <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dummy_q     <= dummy_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      half_q      <= half_d;
      sio_out_q   <= sio_out_d;
      sio_oe_q    <= sio_oe_d;
      quad_mode_q <= quad_mode_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  // Byte array write port; contents survive reset, but a byte landing with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[addr_q] <= {hold_q, sio_in};
  end

endmodule

// File: tb/tb_qspi_sram_responder.sv
// Directed self-checking bench for qspi_sram_responder (default parameters).
module tb_qspi_sram_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_n;
  logic [3:0] sio_in;
  logic [3:0] sio_out;
  logic       sio_oe;
  logic       quad_mode;
  logic       cmd_error;

  int n_checks = 0;
  int n_pass   = 0;
  logic oe_seen;

  always #5 clk = ~clk;

  qspi_sram_responder dut (
    .clk       (clk),
    .reset     (reset),
    .cs_n      (cs_n),
    .sio_in    (sio_in),
    .sio_out   (sio_out),
    .sio_oe    (sio_oe),
    .quad_mode (quad_mode),
    .cmd_error (cmd_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Drive one bus cycle; returns at the following falling edge with outputs settled.
  task automatic drive(input logic cs, input logic [3:0] nib);
    cs_n   = cs;
    sio_in = nib;
    @(negedge clk);
    oe_seen = oe_seen | sio_oe;
  endtask

  task automatic end_cs();
    drive(1'b1, 4'h0);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) drive(1'b0, {3'b000, b[i]});
  endtask

  task automatic quad_byte(input logic [7:0] b);
    drive(1'b0, b[7:4]);
    drive(1'b0, b[3:0]);
  endtask

  task automatic quad_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) drive(1'b0, a[i*4 +: 4]);
  endtask

  // Write n bytes (first byte in bits [31:24]) starting at addr.
  task automatic write_bytes(input logic [23:0] addr, input logic [31:0] data, input int n);
    quad_byte(8'h02);
    quad_addr(addr);
    for (int i = 0; i < n; i++) quad_byte(data[31 - 8*i -: 8]);
    end_cs();
  endtask

  // Read command plus dummies; checks n nibbles (first nibble in bits [31:28]).
  task automatic read_check(input string tag, input logic [23:0] addr,
                            input logic [31:0] exp, input int n, input logic close);
    quad_byte(8'h0B);
    quad_addr(addr);
    oe_seen = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b0, 4'h0);
    check_eq({tag, "_dummy_oe"}, {31'd0, oe_seen}, 32'd0);
    drive(1'b0, 4'h0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) drive(1'b0, 4'h0);
      check_eq($sformatf("%s_nib%0d", tag, i), {27'd0, sio_oe, sio_out}, {27'd1, exp[31 - 4*i -: 4]});
    end
    if (close) begin
      end_cs();
      check_eq({tag, "_oe_drop"}, {31'd0, sio_oe}, 32'd0);
    end
  endtask

  initial begin
    reset   = 1'b1;
    cs_n    = 1'b1;
    sio_in  = 4'h0;
    oe_seen = 1'b0;
    @(negedge clk);
    drive(1'b1, 4'h0);
    drive(1'b1, 4'h0);
    check_eq("reset_outputs", {25'd0, sio_out, sio_oe, quad_mode, cmd_error}, 32'd0);
    reset = 1'b0;
    drive(1'b1, 4'h0);

    // Enter quad mode via serial 0x38.
    oe_seen = 1'b0;
    spi_byte(8'h38);
    check_eq("enter_quad_mode", {31'd0, quad_mode}, 32'd1);
    check_eq("enter_quad_err", {31'd0, cmd_error}, 32'd0);
    end_cs();
    check_eq("enter_quad_kept", {31'd0, quad_mode}, 32'd1);
    check_eq("enter_quad_oe", {31'd0, oe_seen}, 32'd0);

    // 0xDEADBEEF at 0x10, then read it back.
    write_bytes(24'h000010, 32'hEFBEADDE, 4);
    read_check("rd_deadbeef", 24'h000010, 32'hEFBEADDE, 8, 1'b1);

    // Address wrap at 0x3FF.
    write_bytes(24'h0003FF, 32'h11220000, 2);
    read_check("rd_wrap", 24'h0003FF, 32'h11220000, 4, 1'b1);
    read_check("rd_wrap0", 24'h000000, 32'h22000000, 2, 1'b1);

    // Abort mid-byte: only the complete byte lands.
    write_bytes(24'h000020, 32'h33440000, 2);
    quad_byte(8'h02);
    quad_addr(24'h000020);
    quad_byte(8'h5A);
    drive(1'b0, 4'h7);
    end_cs();
    read_check("rd_abort", 24'h000020, 32'h5A440000, 4, 1'b1);

    // Unsupported quad opcode.
    quad_byte(8'h9F);
    check_eq("bad_op_pulse", {31'd0, cmd_error}, 32'd1);
    oe_seen = 1'b0;
    drive(1'b0, 4'h0);
    check_eq("bad_op_one_cycle", {31'd0, cmd_error}, 32'd0);
    quad_byte(8'h0B);
    quad_addr(24'h000010);
    for (int i = 0; i < 8; i++) drive(1'b0, 4'h0);
    check_eq("bad_op_ignored", {30'd0, oe_seen, cmd_error}, 32'd0);
    end_cs();

    // Exit quad; a quad-style 0x0B is now serial opcode 0x42.
    quad_byte(8'hFF);
    check_eq("exit_quad", {31'd0, quad_mode}, 32'd0);
    end_cs();
    oe_seen = 1'b0;
    quad_byte(8'h0B);
    quad_addr(24'h000010);
    check_eq("spi_0x42_err", {31'd0, cmd_error}, 32'd1);
    for (int i = 0; i < 10; i++) drive(1'b0, 4'h0);
    check_eq("no_quad_read", {30'd0, oe_seen, quad_mode}, 32'd0);
    end_cs();

    // Reset during the read data phase.
    spi_byte(8'h38);
    end_cs();
    read_check("rd_pre_reset", 24'h000010, 32'hEF000000, 2, 1'b0);
    reset = 1'b1;
    drive(1'b0, 4'h0);
    check_eq("reset_mid_read", {25'd0, sio_out, sio_oe, quad_mode, cmd_error}, 32'd0);
    reset = 1'b0;
    end_cs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/qspi_sram_responder.md
Name: qspi_sram_responder

Overview:
- Synthesizable QSPI SRAM target: the far end of the quad-SPI link driven by the controller-side shifter.
- Used as the on-chip stand-in for the external SRAM, both for simulation and for FPGA loopback builds.
- Decodes the enter-quad command (serial), then quad write (0x02), quad fast read (0x0B) and reset-quad (0xFF) with 24-bit addresses.
- Stores data in an internal byte-wide array. Tristate SIO pads are resolved at the top level through split in/out/oe ports.

Parameters:
ADDR_BITS, 10, byte address width of the internal array (2^ADDR_BITS bytes); upper bits of the 24-bit address are ignored.
DUMMY_NIBBLES, 6, dummy cycles between the last address nibble and the first read-data nibble for 0x0B.

Ports:
clk  input  1  system clock; the bus is sampled one nibble or bit per rising edge while cs_n is low
reset  input  1  synchronous, active-high reset
cs_n  input  1  chip select, active low
sio_in  input  4  SIO[3:0] as seen at the pads
sio_out  output  4  SIO[3:0] drive value (registered)
sio_oe  output  1  1 = responder drives all four SIO lines
quad_mode  output  1  1 = device is in quad (SQI) mode
cmd_error  output  1  one-cycle pulse when an unsupported opcode is decoded

Behaviour:
- Reset values: sio_out=0, sio_oe=0, quad_mode=0, cmd_error=0, FSM=IDLE, all counters 0. Array contents are not reset.
- Cycle numbering: a cycle is a rising edge with cs_n=0. Cycle 1 is the first such edge after cs_n falls.
- cs_n high on any edge: FSM returns to IDLE, sio_oe=0 on the next edge, quad_mode is kept. Any partial (incomplete) byte is discarded.
- SPI mode (quad_mode=0):
  - Cycles 1-8 shift sio_in[0] MSB-first into the opcode.
  - 0x38: quad_mode=1 at the cycle-8 edge. Any other opcode: cmd_error pulses.
  - In both cases the FSM then goes to IGNORE until cs_n rises.
- Quad mode, opcode phase: cycles 1-2 form the opcode, high nibble first, sio_in[3] = MSB of the nibble.
- Opcode 0xFF: quad_mode=0, then IGNORE.
- Opcode 0x38 (repeated): no-op, then IGNORE.
- Other unsupported opcodes: cmd_error pulses, then IGNORE.
- Opcodes 0x02 and 0x0B: address phase on cycles 3-8, six nibbles, A[23:20] first.
- Byte nibble order on the bus for both write and read: high nibble then low nibble. Bytes go to consecutive addresses, so a 32-bit word appears as [7:4],[3:0],[15:12],[11:8],[23:20],[19:16],[31:28],[27:24].
- WRITE (0x02):
  - From cycle 9, every second nibble completes a byte, which is written to mem[addr] on that edge.
  - addr then increments. It wraps modulo 2^ADDR_BITS.
  - The burst is unbounded until cs_n rises.
- READ (0x0B):
  - Cycles 9..8+DUMMY_NIBBLES are dummy cycles; sio_oe stays 0.
  - On the edge of the last dummy cycle, sio_oe goes to 1 and sio_out gets the high nibble of mem[addr].
  - Each later edge presents the next nibble, so data nibble i is valid for sampling at cycle 8+DUMMY_NIBBLES+i.
  - addr increments after each low nibble is presented, wrapping modulo 2^ADDR_BITS.
  - Output continues until cs_n rises; sio_oe drops on the first edge with cs_n=1.
- Read and write at the same address in one transaction cannot occur; no bypass is required.
- Reset mid-transaction: immediate return to the reset values. A write byte that completes on the same edge as reset is not committed.
- FSM states: IDLE, SPI_CMD, Q_CMD, Q_ADDR, Q_WRITE, Q_DUMMY, Q_READ, IGNORE.
  - IDLE -> SPI_CMD or Q_CMD on cycle 1, depending on quad_mode.
  - Counters: 4-bit bit/nibble counter, 3-bit dummy counter.

Test Plan:
- Enter quad: reset; serial 0x38 on sio0 over 8 cycles; cs_n high -> quad_mode=1, cmd_error=0, sio_oe never asserted.
- Quad write then read: write 0xDEADBEEF at addr 0x000010 using nibbles E,F,B,E,A,D,D,E. Then 0x0B at 0x000010 -> after 6 dummy cycles, sio_out = E,F,B,E,A,D,D,E with sio_oe=1.
- Wrap: with ADDR_BITS=10, write 2 bytes 0x11,0x22 at 0x0003FF -> mem[0x3FF]=0x11, mem[0x000]=0x22. Read from 0x3FF returns the same.
- Abort: write 0x02 at 0x20 with 3 data nibbles, then cs_n high -> mem[0x20] updated, mem[0x21] unchanged. The next transaction decodes normally.
- Bad opcode / exit quad: quad opcode 0x9F -> cmd_error pulses once and the bus is ignored until cs_n rises. Quad opcode 0xFF -> quad_mode=0, and a following quad 0x0B is not executed.
- Reset mid-read: assert reset during the data phase -> sio_oe=0, sio_out=0 and quad_mode=0 on the next edge.
